// File: rtl/spirose_pkg.sv
// rtl/spirose_pkg.sv - shared types and constants for the rotor slice scheduler
package spirose_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MEASURE,
        RUN
    } sched_state_t;

    localparam int DEFAULT_NB_SLICES = 128;

    // One full 9-bit poker GCLK segment plus the pause that follows it.
    localparam int SEGMENT_CYCLES = 513;

endpackage

// File: rtl/hall_edge_detect.sv
// rtl/hall_edge_detect.sv - Hall sensor synchronizer and falling-edge pulse
//
// clk_lse   : clock
// nrst      : asynchronous active-low reset
// hall_n    : raw asynchronous Hall input, idles high, low pulse once per turn
// hall_edge : one-cycle pulse, two cycles after hall_n is first sampled low
module hall_edge_detect (
    input  logic clk_lse,
    input  logic nrst,
    input  logic hall_n,
    output logic hall_edge
);

    logic sync1;
    logic sync2;
    logic sync_d;

    // Flops reset high so an idle sensor does not produce an edge at reset release.
    always_ff @(posedge clk_lse or negedge nrst) begin
        if (!nrst) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            sync_d    <= 1'b1;
            hall_edge <= 1'b0;
        end else begin
            sync1     <= hall_n;
            sync2     <= sync1;
            sync_d    <= sync2;
            hall_edge <= sync_d & ~sync2;
        end
    end

endmodule

// File: rtl/slice_scheduler.sv
// rtl/slice_scheduler.sv - measures rotor period and emits per-slice sync pulses
//
// clk_lse          : clock
// nrst             : asynchronous active-low reset
// hall_n           : raw Hall sensor, one low pulse per turn
// driver_ready     : gates framebuffer_sync while the driver is configuring
// framebuffer_sync : one-cycle pulse at each slice start
// slice_index      : index of the current slice
// rotation_valid   : high while slices are being generated
// overspeed        : last measured slice length was below MIN_SLICE_LEN
// period_measured  : last latched rotation period in cycles
module slice_scheduler
    import spirose_pkg::*;
#(
    parameter int  NB_SLICES     = DEFAULT_NB_SLICES,
    parameter int  PERIOD_WIDTH  = 24,
    parameter int  MIN_SLICE_LEN = SEGMENT_CYCLES,
    localparam int IDX_W         = $clog2(NB_SLICES)
) (
    input  logic                    clk_lse,
    input  logic                    nrst,
    input  logic                    hall_n,
    input  logic                    driver_ready,
    output logic                    framebuffer_sync,
    output logic [IDX_W-1:0]        slice_index,
    output logic                    rotation_valid,
    output logic                    overspeed,
    output logic [PERIOD_WIDTH-1:0] period_measured
);

    localparam logic [PERIOD_WIDTH-1:0] PERIOD_MAX = '1;
    localparam logic [PERIOD_WIDTH-1:0] MIN_LEN    = PERIOD_WIDTH'(MIN_SLICE_LEN);
    localparam logic [PERIOD_WIDTH-1:0] ONE        = PERIOD_WIDTH'(1);
    localparam logic [IDX_W-1:0]        LAST_IDX   = IDX_W'(NB_SLICES - 1);

    logic                    hall_edge;
    sched_state_t            state, state_n;
    logic [PERIOD_WIDTH-1:0] period_cnt, period_cnt_n;
    logic [PERIOD_WIDTH-1:0] slice_len, slice_len_n;
    logic [PERIOD_WIDTH-1:0] slice_cnt, slice_cnt_n;
    logic [PERIOD_WIDTH-1:0] new_len;
    logic [IDX_W-1:0]        index_n;
    logic [PERIOD_WIDTH-1:0] period_n;
    logic                    overspeed_n;
    logic                    pulse;
    logic                    timeout;

    hall_edge_detect u_hall (
        .clk_lse   (clk_lse),
        .nrst      (nrst),
        .hall_n    (hall_n),
        .hall_edge (hall_edge)
    );

    assign new_len = period_cnt >> IDX_W;
    assign timeout = (period_cnt == PERIOD_MAX);

    always_ff @(posedge clk_lse or negedge nrst) begin
        if (!nrst) begin
            state            <= IDLE;
            period_cnt       <= '0;
            slice_len        <= '0;
            slice_cnt        <= '0;
            slice_index      <= '0;
            framebuffer_sync <= 1'b0;
            rotation_valid   <= 1'b0;
            overspeed        <= 1'b0;
            period_measured  <= '0;
        end else begin
            state            <= state_n;
            period_cnt       <= period_cnt_n;
            slice_len        <= slice_len_n;
            slice_cnt        <= slice_cnt_n;
            slice_index      <= index_n;
            framebuffer_sync <= pulse & driver_ready;
            rotation_valid   <= (state_n == RUN);
            overspeed        <= overspeed_n;
            period_measured  <= period_n;
        end
    end

    always_comb begin
        state_n      = state;
        period_cnt_n = hall_edge ? ONE : (timeout ? period_cnt : period_cnt + ONE);
        slice_len_n  = hall_edge ? new_len : slice_len;
        slice_cnt_n  = slice_cnt;
        index_n      = slice_index;
        period_n     = period_measured;
        overspeed_n  = overspeed;
        pulse        = 1'b0;

        case (state)
            IDLE: begin
                if (hall_edge) begin
                    state_n = MEASURE;
                end
            end
            MEASURE, RUN: begin
                // A saturated period counter beats a coincident Hall edge.
                if (timeout) begin
                    state_n     = IDLE;
                    index_n     = '0;
                    slice_cnt_n = '0;
                end else if (hall_edge) begin
                    // A Hall edge also pre-empts a coincident slice wrap: one pulse, index 0.
                    period_n    = period_cnt;
                    index_n     = '0;
                    slice_cnt_n = '0;
                    if (new_len >= MIN_LEN) begin
                        state_n     = RUN;
                        overspeed_n = 1'b0;
                        pulse       = 1'b1;
                    end else begin
                        state_n     = MEASURE;
                        overspeed_n = 1'b1;
                    end
                end else if (state == RUN) begin
                    if (slice_cnt == slice_len - ONE) begin
                        slice_cnt_n = '0;
                        // Rotor slowing down: park on the last slice until the Hall edge.
                        if (slice_index != LAST_IDX) begin
                            index_n = slice_index + IDX_W'(1);
                            pulse   = 1'b1;
                        end
                    end else begin
                        slice_cnt_n = slice_cnt + ONE;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_slice_scheduler.sv
// tb/tb_slice_scheduler.sv - self-checking bench for slice_scheduler
module tb_slice_scheduler;

    localparam int NB   = 8;
    localparam int PW   = 12;
    localparam int MINL = 20;
    localparam int LOGN = 3;
    localparam int PMAX = (1 << PW) - 1;
    localparam int MAXC = 16000;

    logic          clk_lse = 1'b0;
    logic          nrst = 1'b0;
    logic          hall_n = 1'b1;
    logic          driver_ready = 1'b0;
    logic          framebuffer_sync;
    logic [2:0]    slice_index;
    logic          rotation_valid;
    logic          overspeed;
    logic [PW-1:0] period_measured;

    always #5 clk_lse = ~clk_lse;

    slice_scheduler #(
        .NB_SLICES     (NB),
        .PERIOD_WIDTH  (PW),
        .MIN_SLICE_LEN (MINL)
    ) dut (
        .clk_lse          (clk_lse),
        .nrst             (nrst),
        .hall_n           (hall_n),
        .driver_ready     (driver_ready),
        .framebuffer_sync (framebuffer_sync),
        .slice_index      (slice_index),
        .rotation_valid   (rotation_valid),
        .overspeed        (overspeed),
        .period_measured  (period_measured)
    );

    int checks = 0;
    int errors = 0;

    bit hall_s [MAXC+1];
    bit rdy_s  [MAXC+1];
    int edges  [$];
    bit o_sync [MAXC+1];
    int o_idx  [MAXC+1];
    bit o_rv   [MAXC+1];
    bit o_ov   [MAXC+1];
    int o_pm   [MAXC+1];

    typedef struct {
        int period;
        bit ready;
        int exp_pm;
        int exp_ov;
        int exp_rv;
        int exp_pulses;
    } vec_t;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic int pack(input int s, input int idx, input int rv, input int ov, input int pm);
        return (pm << 6) | (ov << 5) | (rv << 4) | (idx << 1) | s;
    endfunction

    // Hall pulses are three cycles low; edges[] holds the cycle in which the
    // conditioned edge is expected (two cycles after the first low sample).
    task automatic build(input int first, input int gaps[$]);
        int t;
        edges.delete();
        for (int c = 0; c <= MAXC; c++) begin
            hall_s[c] = 1'b1;
            rdy_s[c]  = 1'b1;
        end
        t = first;
        for (int i = 0; i <= gaps.size(); i++) begin
            for (int j = 0; j < 3; j++)
                if (t + j <= MAXC) hall_s[t+j] = 1'b0;
            edges.push_back(t + 2);
            if (i < gaps.size()) t += gaps[i];
        end
    endtask

    function automatic bit is_edge(input int c);
        return (c >= 3) && !hall_s[c-2] && hall_s[c-3];
    endfunction

    // Reference: walks the Hall edges turn by turn; inside a turn the slice
    // index is just elapsed cycles divided by the slice length.
    task automatic check_model(input int ncyc);
        int mode, lc, rs, len, pm, ov, p, k, s, idx, exp_v, got_v;
        mode = 0; lc = -1000000; rs = 0; len = 1; pm = 0; ov = 0;
        chk("reset_state", pack(o_sync[0], o_idx[0], o_rv[0], o_ov[0], o_pm[0]), 0);
        for (int c = 0; c < ncyc; c++) begin
            s = 0;
            if (mode != 0 && (c - lc) >= PMAX) begin
                mode = 0;
            end else if (is_edge(c)) begin
                p = (c - lc) > PMAX ? PMAX : (c - lc);
                if (mode == 0) begin
                    mode = 1;
                end else begin
                    pm = p;
                    if ((p >> LOGN) >= MINL) begin
                        mode = 2; rs = c + 1; len = p >> LOGN; ov = 0; s = 1;
                    end else begin
                        mode = 1; ov = 1;
                    end
                end
            end else if (mode == 2) begin
                k = c + 1 - rs;
                if ((k % len) == 0 && (k / len) <= NB - 1) s = 1;
            end
            if (is_edge(c)) lc = c;
            idx = 0;
            if (mode == 2) begin
                idx = (c + 1 - rs) / len;
                if (idx > NB - 1) idx = NB - 1;
            end
            exp_v = pack(s & rdy_s[c+1], idx, (mode == 2) ? 1 : 0, ov, pm);
            got_v = pack(o_sync[c+1], o_idx[c+1], o_rv[c+1], o_ov[c+1], o_pm[c+1]);
            chk($sformatf("trace c=%0d", c + 1), got_v, exp_v);
        end
    endtask

    task automatic sample(input int c);
        o_sync[c] = framebuffer_sync;
        o_idx[c]  = int'(slice_index);
        o_rv[c]   = rotation_valid;
        o_ov[c]   = overspeed;
        o_pm[c]   = int'(period_measured);
    endtask

    task automatic run(input int ncyc);
        nrst = 1'b0; hall_n = 1'b1; driver_ready = 1'b1;
        repeat (2) @(negedge clk_lse);
        nrst = 1'b1;
        sample(0);
        for (int c = 1; c <= ncyc; c++) begin
            hall_n       = hall_s[c];
            driver_ready = rdy_s[c];
            @(posedge clk_lse);
            @(negedge clk_lse);
            sample(c);
        end
        check_model(ncyc);
    endtask

    function automatic int count_pulses(input int a, input int b);
        int n = 0;
        for (int c = a + 1; c <= b; c++) n += o_sync[c];
        return n;
    endfunction

    function automatic int first_pulse(input int ncyc);
        for (int c = 0; c <= ncyc; c++) if (o_sync[c]) return c;
        return -1;
    endfunction

    vec_t vecs [8];
    int   g [$];
    int   e2, n, fp, tot, gp, r;
    bit   seg;

    initial begin
        vecs[0] = '{256,  1'b1, 256,  0, 1, 8};
        vecs[1] = '{200,  1'b1, 200,  0, 1, 8};
        vecs[2] = '{160,  1'b1, 160,  0, 1, 8};
        vecs[3] = '{159,  1'b1, 159,  1, 0, 0};
        vecs[4] = '{100,  1'b1, 100,  1, 0, 0};
        vecs[5] = '{3000, 1'b1, 3000, 0, 1, 8};
        vecs[6] = '{4094, 1'b1, 4094, 0, 1, 8};
        vecs[7] = '{256,  1'b0, 256,  0, 1, 0};

        for (int i = 0; i < 8; i++) begin
            g = {vecs[i].period, vecs[i].period, vecs[i].period};
            build(5, g);
            if (!vecs[i].ready)
                for (int c = 0; c <= MAXC; c++) rdy_s[c] = 1'b0;
            n = edges[3] + 4;
            run(n);
            chk($sformatf("tbl%0d_pm", i), o_pm[edges[3]+2], vecs[i].exp_pm);
            chk($sformatf("tbl%0d_ov", i), o_ov[edges[3]+2], vecs[i].exp_ov);
            chk($sformatf("tbl%0d_rv", i), o_rv[edges[3]+2], vecs[i].exp_rv);
            chk($sformatf("tbl%0d_pulses", i), count_pulses(edges[2], edges[3]), vecs[i].exp_pulses);
        end

        // Speed-up with an edge landing on a slice wrap, then slow-down holding slice 7.
        g = {256, 256, 224, 280, 280};
        build(5, g);
        run(edges[5] + 5);
        chk("fast_idx_before_edge", o_idx[edges[3]], 6);
        chk("fast_edge_sync", o_sync[edges[3]+1], 1);
        chk("fast_edge_idx", o_idx[edges[3]+1], 0);
        chk("fast_turn_pulses", count_pulses(edges[2], edges[3]+1), 8);
        chk("slow_idx_hold", o_idx[edges[4]], 7);
        chk("slow_turn_pulses", count_pulses(edges[3], edges[4]), 8);
        chk("slow_no_extra", count_pulses(edges[3]+1+7*28, edges[4]), 0);

        // Overspeed from RUN, then recovery.
        g = {256, 100, 100, 256, 256};
        build(5, g);
        run(edges[5] + 5);
        chk("ovs_set", o_ov[edges[2]+1], 1);
        chk("ovs_rv", o_rv[edges[2]+1], 0);
        chk("ovs_no_sync", o_sync[edges[2]+1], 0);
        chk("ovs_silent", count_pulses(edges[2], edges[4]), 0);
        chk("ovs_clear", o_ov[edges[4]+1], 0);
        chk("ovs_resume_sync", o_sync[edges[4]+1], 1);
        chk("ovs_resume_pm", o_pm[edges[4]+1], 256);

        // Stall timeout.
        g = {256, 256};
        build(5, g);
        e2 = edges[2];
        run(e2 + 4100);
        chk("to_rv_before", o_rv[e2+4095], 1);
        chk("to_idx_before", o_idx[e2+4095], 7);
        chk("to_rv_after", o_rv[e2+4096], 0);
        chk("to_idx_after", o_idx[e2+4096], 0);
        chk("to_no_pulses", count_pulses(e2 + 230, e2 + 4100), 0);
        chk("to_pm_kept", o_pm[e2+4100], 256);

        // driver_ready low until mid-slice 5 of the second running turn.
        g = {256, 256, 256};
        build(5, g);
        e2 = edges[2];
        for (int c = 0; c <= e2 + 171; c++) rdy_s[c] = 1'b0;
        run(edges[3] + 5);
        fp = first_pulse(edges[3] + 5);
        chk("rdy_first_pulse", fp, e2 + 193);
        chk("rdy_first_idx", (fp >= 0) ? o_idx[fp] : -1, 6);

        // Asynchronous reset while running.
        chk("pre_rst_rv", rotation_valid, 1);
        nrst = 1'b0;
        #1;
        chk("rst_sync", framebuffer_sync, 0);
        chk("rst_idx", slice_index, 0);
        chk("rst_rv", rotation_valid, 0);
        chk("rst_ov", overspeed, 0);
        chk("rst_pm", period_measured, 0);
        g = {256, 256};
        build(5, g);
        run(edges[2] + 5);
        chk("rst_first_pulse", first_pulse(edges[2] + 5), edges[1] + 1);

        // Randomized Hall periods and driver_ready windows.
        for (int rep = 0; rep < 2; rep++) begin
            g.delete();
            tot = 7;
            while (tot < MAXC - 4400) begin
                r = $urandom_range(0, 19);
                if (r == 0)     gp = 4200;
                else if (r < 4) gp = $urandom_range(80, 159);
                else            gp = $urandom_range(160, 420);
                g.push_back(gp);
                tot += gp;
            end
            build(5, g);
            seg = 1'b1;
            for (int c = 0; c <= MAXC; c++) begin
                if (c % 64 == 0) seg = ($urandom_range(0, 3) != 0);
                rdy_s[c] = seg;
            end
            run(tot + 150);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
